// File: rtl/axis_i2c_pkg.sv
// Shared types and command-word layout for the AXI-Stream to I2C bridge.
package axis_i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WRITE,
    ST_WRITE_ACK,
    ST_READ,
    ST_READ_ACK,
    ST_STOP
  } i2c_state_e;

  // Command word: {addr[6:0], rw, wdata[7:0]}
  localparam int ADDR_MSB = 15;
  localparam int RW_BIT   = 8;
  localparam int DATA_MSB = 7;

  // SCL level for a bit-slot phase: high in the two middle phases.
  function automatic logic bit_scl(input logic [1:0] ph);
    return (ph == 2'd1) || (ph == 2'd2);
  endfunction

endpackage

// File: rtl/axis_i2c_cmd_fifo.sv
// Small synchronous command FIFO with a combinational head-of-queue output.
module axis_i2c_cmd_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wptr_q, rptr_q;
  logic [AW:0]           cnt_q;
  logic                  push, pop;

  assign full_o    = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign push      = wr_en_i && !full_o;
  assign pop       = rd_en_i && !empty_o;
  assign rd_data_o = mem_q[rptr_q];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at the depth.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      if (push && !pop)      cnt_q <= cnt_q + (AW+1)'(1);
      else if (pop && !push) cnt_q <= cnt_q - (AW+1)'(1);
    end
  end

  // Storage array; contents need no reset since the count gates visibility.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/axis_i2c_master_core.sv
// AXI-Stream command input to single-byte I2C master transactions; read bytes
// return on an AXI-Stream master port. SCL runs at a quarter of the tick rate.
module axis_i2c_master_core
  import axis_i2c_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int I2C_DATA_WIDTH = 8,
  parameter int MAIN_CLK       = 100_000_000,
  parameter int I2C_CLK        = 200_000
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      en_i,
  output logic                      i2c_scl_o,
  inout  wire                       i2c_sda_io,
  output logic [I2C_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  output logic                      nack_o
);

  localparam int QDIV  = MAIN_CLK / (4 * I2C_CLK);
  localparam int CNT_W = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam int BIT_W = $clog2(I2C_DATA_WIDTH);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             qtick;

  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_full, fifo_empty, pop;

  i2c_state_e                state_q;
  logic [1:0]                phase_q;
  logic [BIT_W-1:0]          bit_q;
  logic [DATA_WIDTH-1:0]     cmd_q;
  logic [I2C_DATA_WIDTH-1:0] shift_q, tdata_q;
  logic                      scl_q, sda_low_q, nack_q, nack_seen_q, read_ok_q, tvalid_q;

  logic [ADDR_MSB-RW_BIT:0] addr_byte;
  logic [DATA_MSB:0]        wdata_byte;
  logic                     sda_in;

  assign addr_byte  = cmd_q[ADDR_MSB:RW_BIT];
  assign wdata_byte = cmd_q[DATA_MSB:0];
  assign sda_in     = i2c_sda_io;
  assign i2c_sda_io = sda_low_q ? 1'b0 : 1'bz;

  assign i2c_scl_o     = scl_q;
  assign nack_o        = nack_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign s_axis_tready = !fifo_full;

  assign pop = qtick && (state_q == ST_IDLE) && !fifo_empty && !tvalid_q;

  axis_i2c_cmd_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (s_axis_tvalid),
    .wr_data_i (s_axis_tdata),
    .rd_en_i   (pop),
    .rd_data_o (fifo_dout),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Quarter-bit tick: count held while disabled, which freezes the engine.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = (cnt_q == CNT_W'(QDIV - 1)) ? '0 : cnt_q + CNT_W'(1);
  end

  assign qtick = en_i && (cnt_q == CNT_W'(QDIV - 1));

  // Tick counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // I2C engine: one phase per tick, four phases per bit slot, registered pins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      phase_q     <= 2'd0;
      bit_q       <= BIT_W'(I2C_DATA_WIDTH - 1);
      scl_q       <= 1'b1;
      sda_low_q   <= 1'b0;
      nack_q      <= 1'b0;
      nack_seen_q <= 1'b0;
      read_ok_q   <= 1'b0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
    end else begin
      nack_q <= 1'b0;
      if (tvalid_q && m_axis_tready) tvalid_q <= 1'b0;
      if (qtick) begin
        if (state_q != ST_IDLE) phase_q <= phase_q + 2'd1;
        case (state_q)
          ST_IDLE: begin
            scl_q     <= 1'b1;
            sda_low_q <= 1'b0;
            if (pop) begin
              cmd_q     <= fifo_dout;
              read_ok_q <= 1'b0;
              phase_q   <= 2'd0;
              state_q   <= ST_START;
            end
          end
          ST_START: begin
            scl_q     <= (phase_q < 2'd2);
            sda_low_q <= 1'b1;
            if (phase_q == 2'd3) begin
              bit_q   <= BIT_W'(I2C_DATA_WIDTH - 1);
              state_q <= ST_ADDR;
            end
          end
          ST_ADDR, ST_WRITE: begin
            scl_q <= bit_scl(phase_q);
            if (phase_q == 2'd0)
              sda_low_q <= (state_q == ST_ADDR) ? !addr_byte[bit_q] : !wdata_byte[bit_q];
            if (phase_q == 2'd3) begin
              bit_q <= bit_q - BIT_W'(1);
              if (bit_q == '0) state_q <= (state_q == ST_ADDR) ? ST_ADDR_ACK : ST_WRITE_ACK;
            end
          end
          ST_ADDR_ACK, ST_WRITE_ACK: begin
            scl_q <= bit_scl(phase_q);
            if (phase_q == 2'd0) sda_low_q <= 1'b0;
            if (phase_q == 2'd2) begin
              nack_seen_q <= sda_in;
              nack_q      <= sda_in;
            end
            if (phase_q == 2'd3) begin
              if (state_q == ST_WRITE_ACK || nack_seen_q) begin
                state_q <= ST_STOP;
              end else if (cmd_q[RW_BIT]) begin
                read_ok_q <= 1'b1;
                state_q   <= ST_READ;
              end else begin
                state_q <= ST_WRITE;
              end
            end
          end
          ST_READ: begin
            scl_q <= bit_scl(phase_q);
            if (phase_q == 2'd0) sda_low_q <= 1'b0;
            if (phase_q == 2'd2) shift_q <= {shift_q[I2C_DATA_WIDTH-2:0], sda_in};
            if (phase_q == 2'd3) begin
              bit_q <= bit_q - BIT_W'(1);
              if (bit_q == '0) state_q <= ST_READ_ACK;
            end
          end
          ST_READ_ACK: begin
            scl_q <= bit_scl(phase_q);
            if (phase_q == 2'd0) sda_low_q <= 1'b0;
            if (phase_q == 2'd3) state_q <= ST_STOP;
          end
          ST_STOP: begin
            scl_q     <= (phase_q != 2'd0);
            sda_low_q <= (phase_q != 2'd3);
            if (phase_q == 2'd3) begin
              state_q <= ST_IDLE;
              if (read_ok_q) begin
                tvalid_q <= 1'b1;
                tdata_q  <= shift_q;
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axis_i2c_master_core.sv
// Directed bench for axis_i2c_master_core with a pin-level I2C slave model.
module tb_axis_i2c_master_core;

  localparam int QDIV = 5;

  logic        clk = 1'b0;
  logic        rst_i, en_i, m_axis_tready, s_axis_tvalid;
  logic [15:0] s_axis_tdata;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid, s_axis_tready, nack_o, scl;
  wire         sda_w;

  logic        slave_low = 1'b0;
  logic        ack_en = 1'b1;
  logic [7:0]  txbyte = 8'h3C;

  pullup (sda_w);
  assign sda_w = slave_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  axis_i2c_master_core #(
    .FIFO_DEPTH (4), .DATA_WIDTH (16), .I2C_DATA_WIDTH (8),
    .MAIN_CLK (4_000_000), .I2C_CLK (200_000)
  ) dut (
    .clk_i (clk), .rst_i (rst_i), .en_i (en_i),
    .i2c_scl_o (scl), .i2c_sda_io (sda_w),
    .m_axis_tdata (m_axis_tdata), .m_axis_tvalid (m_axis_tvalid), .m_axis_tready (m_axis_tready),
    .s_axis_tdata (s_axis_tdata), .s_axis_tvalid (s_axis_tvalid), .s_axis_tready (s_axis_tready),
    .nack_o (nack_o)
  );

  // Monitor and slave state, written only by the monitor process.
  int         cyc = 0, edge_cnt = 0, start_cnt = 0, stop_cnt = 0, start_t = 0, stop_t = 0;
  int         nack_hi = 0, nack_rise = 0, tv_rise = 0, tv_rise_t = 0;
  int         bitc = 0, byte_no = 0, addr_cnt = 0, wcnt = 0;
  logic       prev_scl = 1'b1, prev_sda = 1'b1, prev_nack = 1'b0, prev_tv = 1'b0;
  logic       rd_mode = 1'b0, master_ack = 1'b0;
  logic [7:0] shreg = 8'h00;
  logic [7:0] addr_log [8];
  logic [7:0] wdata_log [8];

  // Pin-level monitor and byte-oriented slave, sampled on the falling clock edge.
  always @(negedge clk) begin
    cyc       <= cyc + 1;
    prev_scl  <= scl;
    prev_sda  <= sda_w;
    prev_nack <= nack_o;
    prev_tv   <= m_axis_tvalid;
    if (scl != prev_scl || sda_w != prev_sda) edge_cnt <= edge_cnt + 1;
    if (nack_o) nack_hi <= nack_hi + 1;
    if (nack_o && !prev_nack) nack_rise <= nack_rise + 1;
    if (m_axis_tvalid && !prev_tv) begin
      tv_rise   <= tv_rise + 1;
      tv_rise_t <= cyc;
    end
    if (prev_scl && scl && prev_sda && !sda_w) begin
      start_cnt <= start_cnt + 1;
      start_t   <= cyc;
      bitc      <= 0;
      byte_no   <= 0;
      rd_mode   <= 1'b0;
      slave_low <= 1'b0;
    end else if (prev_scl && scl && !prev_sda && sda_w) begin
      stop_cnt  <= stop_cnt + 1;
      stop_t    <= cyc;
      slave_low <= 1'b0;
    end else if (!prev_scl && scl) begin
      if (bitc < 8) begin
        shreg <= {shreg[6:0], sda_w};
        bitc  <= bitc + 1;
        if (bitc == 7 && byte_no == 0) begin
          addr_log[addr_cnt % 8] <= {shreg[6:0], sda_w};
          addr_cnt <= addr_cnt + 1;
        end
        if (bitc == 7 && byte_no == 1 && !rd_mode) begin
          wdata_log[wcnt % 8] <= {shreg[6:0], sda_w};
          wcnt <= wcnt + 1;
        end
      end else if (bitc == 8) begin
        bitc <= 9;
        if (byte_no == 1 && rd_mode) master_ack <= sda_w;
      end
    end else if (prev_scl && !scl) begin
      if (bitc == 8) begin
        if (byte_no == 0) begin
          slave_low <= ack_en;
          rd_mode   <= ack_en && shreg[0];
        end else if (!rd_mode) slave_low <= ack_en;
        else slave_low <= 1'b0;
      end else if (bitc == 9) begin
        bitc      <= 0;
        byte_no   <= byte_no + 1;
        slave_low <= (byte_no == 0 && rd_mode) ? !txbyte[7] : 1'b0;
      end else if (rd_mode && byte_no == 1 && bitc >= 1) begin
        slave_low <= !txbyte[7 - bitc];
      end else begin
        slave_low <= 1'b0;
      end
    end
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] w);
    @(negedge clk);
    chk("push_tready", 32'(s_axis_tready), 32'd1);
    s_axis_tdata  = w;
    s_axis_tvalid = 1'b1;
    @(negedge clk);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_stops(input int target, input int budget, input string tag);
    int n = 0;
    while (stop_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(stop_cnt >= target), 32'd1);
  endtask

  task automatic wait_tv(input int target, input int budget, input string tag);
    int n = 0;
    while (tv_rise < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(tv_rise >= target), 32'd1);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, st0, nk0, nr0, tv0, a0, w0, e0;
    logic scl_s, sda_s;

    rst_i = 1'b1; en_i = 1'b1; m_axis_tready = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tdata = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_scl", 32'(scl), 32'd1);
    chk("rst_sda", 32'(sda_w), 32'd1);
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_tdata", 32'(m_axis_tdata), 32'd0);
    chk("rst_nack", 32'(nack_o), 32'd0);
    chk("rst_tready", 32'(s_axis_tready), 32'd1);
    rst_i = 1'b0;
    repeat (10) @(negedge clk);

    // Write with an acknowledging slave.
    s0 = start_cnt; st0 = stop_cnt; nr0 = nack_rise; tv0 = tv_rise; a0 = addr_cnt; w0 = wcnt;
    push(16'hA45A);
    wait_stops(st0 + 1, 2000, "wr_done");
    chk("wr_starts", 32'(start_cnt - s0), 32'd1);
    chk("wr_addr", 32'(addr_log[a0 % 8]), 32'hA4);
    chk("wr_data", 32'(wdata_log[w0 % 8]), 32'h5A);
    chk("wr_len", 32'(stop_t - start_t), 32'(79 * QDIV));
    chk("wr_no_nack", 32'(nack_rise - nr0), 32'd0);
    repeat (20) @(negedge clk);
    chk("wr_no_m_axis", 32'(tv_rise - tv0), 32'd0);

    // Read; slave returns 0x3C and the master NACKs the data byte.
    st0 = stop_cnt; a0 = addr_cnt; txbyte = 8'h3C;
    push(16'hA500);
    wait_tv(tv0 + 1, 2000, "rd_valid");
    chk("rd_addr", 32'(addr_log[a0 % 8]), 32'hA5);
    chk("rd_tdata", 32'(m_axis_tdata), 32'h3C);
    chk("rd_master_nack", 32'(master_ack), 32'd1);
    chk("rd_len", 32'(stop_t - start_t), 32'(79 * QDIV));
    chk("rd_tvalid_at_stop", 32'(tv_rise_t), 32'(stop_t));
    repeat (50) @(negedge clk);
    chk("rd_tvalid_held", 32'(m_axis_tvalid), 32'd1);
    m_axis_tready = 1'b1;
    @(negedge clk);
    m_axis_tready = 1'b0;
    chk("rd_tvalid_cleared", 32'(m_axis_tvalid), 32'd0);

    // Address NACK: slave leaves SDA high.
    ack_en = 1'b0; st0 = stop_cnt; nr0 = nack_rise; nk0 = nack_hi; tv0 = tv_rise; a0 = addr_cnt; w0 = wcnt;
    push(16'h9011);
    wait_stops(st0 + 1, 2000, "nk_done");
    chk("nk_addr", 32'(addr_log[a0 % 8]), 32'h90);
    chk("nk_pulses", 32'(nack_rise - nr0), 32'd1);
    chk("nk_width", 32'(nack_hi - nk0), 32'd1);
    chk("nk_len", 32'(stop_t - start_t), 32'(43 * QDIV));
    chk("nk_no_data", 32'(wcnt - w0), 32'd0);
    chk("nk_no_m_axis", 32'(tv_rise - tv0), 32'd0);
    ack_en = 1'b1;
    repeat (20) @(negedge clk);

    // FIFO full: fill while the engine is frozen.
    en_i = 1'b0; st0 = stop_cnt; a0 = addr_cnt; w0 = wcnt;
    push(16'h1001); push(16'h2002); push(16'h3003); push(16'h4004);
    chk("ff_full", 32'(s_axis_tready), 32'd0);
    s_axis_tdata = 16'h5005; s_axis_tvalid = 1'b1;
    repeat (3) @(negedge clk);
    s_axis_tvalid = 1'b0;
    en_i = 1'b1;
    wait_stops(st0 + 4, 4000, "ff_done");
    repeat (20) @(negedge clk);
    chk("ff_count", 32'(addr_cnt - a0), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("ff_addr_order", 32'(addr_log[(a0 + i) % 8]), 32'((i + 1) * 16));
      chk("ff_data_order", 32'(wdata_log[(w0 + i) % 8]), 32'(i + 1));
    end

    // Back-pressure: second read waits for the first result to be consumed.
    s0 = start_cnt; tv0 = tv_rise; a0 = addr_cnt; txbyte = 8'h3C;
    push(16'hA500); push(16'hA700);
    wait_tv(tv0 + 1, 2000, "bp_first");
    chk("bp_first_data", 32'(m_axis_tdata), 32'h3C);
    repeat (1000) @(negedge clk);
    chk("bp_second_held", 32'(start_cnt - s0), 32'd1);
    chk("bp_tvalid_held", 32'(m_axis_tvalid), 32'd1);
    chk("bp_tdata_stable", 32'(m_axis_tdata), 32'h3C);
    txbyte = 8'hC3;
    m_axis_tready = 1'b1;
    @(negedge clk);
    m_axis_tready = 1'b0;
    wait_tv(tv0 + 2, 2000, "bp_second");
    chk("bp_second_data", 32'(m_axis_tdata), 32'hC3);
    chk("bp_second_addr", 32'(addr_log[(a0 + 1) % 8]), 32'hA7);
    m_axis_tready = 1'b1;
    @(negedge clk);
    m_axis_tready = 1'b0;
    repeat (20) @(negedge clk);

    // Enable freeze mid-byte, then reset mid-address.
    s0 = start_cnt;
    push(16'hA45A);
    while (start_cnt == s0 && cyc < 400000) @(negedge clk);
    chk("en_started", 32'(start_cnt - s0), 32'd1);
    repeat (60) @(negedge clk);
    en_i = 1'b0;
    repeat (2) @(negedge clk);
    scl_s = scl; sda_s = sda_w; e0 = edge_cnt;
    push(16'h2202);
    repeat (1000) @(negedge clk);
    chk("en_scl_frozen", 32'(scl), 32'(scl_s));
    chk("en_sda_frozen", 32'(sda_w), 32'(sda_s));
    chk("en_no_edges", 32'(edge_cnt - e0), 32'd0);
    en_i = 1'b1;
    repeat (40) @(negedge clk);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_scl", 32'(scl), 32'd1);
    chk("mid_rst_sda", 32'(sda_w), 32'd1);
    chk("mid_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("mid_rst_tready", 32'(s_axis_tready), 32'd1);
    @(negedge clk);
    rst_i = 1'b0;
    s0 = start_cnt;
    repeat (2000) @(negedge clk);
    chk("mid_rst_fifo_flushed", 32'(start_cnt - s0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
